// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU memory bus: level-held rd/wr with
// parameterised wait states, registered read data with output-enable, preload port.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          RD_WAIT_C = 4'(RD_WAIT);
  localparam logic [3:0]          WR_WAIT_C = 4'(WR_WAIT);

  if (RD_WAIT < 0 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("RD_WAIT must be in 0..15");
  end
  if (WR_WAIT < 0 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("WR_WAIT must be in 0..15");
  end
  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH) || IDX_W > ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH must be in 2..2**ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_HOLD,
    S_WR_WAIT,
    S_WR_HOLD,
    S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_oe_q, data_oe_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [IDX_W-1:0]       rd_idx;
  logic                   addr_oor;
  logic                   init_oor;

  assign addr_oor = ({1'b0, addr} >= DEPTH_C);
  assign init_oor = ({1'b0, init_addr} >= DEPTH_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    ready_d    = ready_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q[IDX_W-1:0];
    mem_wdata  = data_q;
    rd_idx     = addr_q[IDX_W-1:0];

    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rd_idx    = addr[IDX_W-1:0];
        if ((rd && wr) || ((rd || wr) && addr_oor)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (rd) begin
          addr_d = addr;
          cnt_d  = RD_WAIT_C;
          if (RD_WAIT_C == 4'd0) begin
            data_out_d = mem[rd_idx];
            data_oe_d  = 1'b1;
            ready_d    = 1'b1;
            state_d    = S_RD_HOLD;
          end else begin
            state_d = S_RD_WAIT;
          end
        end else if (wr) begin
          addr_d = addr;
          data_d = data_in;
          cnt_d  = WR_WAIT_C;
          if (WR_WAIT_C == 4'd0) begin
            mem_we    = 1'b1;
            mem_waddr = addr[IDX_W-1:0];
            mem_wdata = data_in;
            ready_d   = 1'b1;
            state_d   = S_WR_HOLD;
          end else begin
            state_d = S_WR_WAIT;
          end
        end else if (init_we && !init_oor) begin
          mem_we    = 1'b1;
          mem_waddr = init_addr[IDX_W-1:0];
          mem_wdata = init_data;
        end
      end
      // A dropped request during the wait aborts; nothing is read or written.
      S_RD_WAIT: begin
        if (!rd) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            data_out_d = mem[rd_idx];
            data_oe_d  = 1'b1;
            ready_d    = 1'b1;
            state_d    = S_RD_HOLD;
          end
        end
      end
      S_WR_WAIT: begin
        if (!wr) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            mem_we  = 1'b1;
            ready_d = 1'b1;
            state_d = S_WR_HOLD;
          end
        end
      end
      S_RD_HOLD: begin
        if (!rd) begin
          ready_d   = 1'b0;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WR_HOLD: begin
        if (!wr) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        ready_d   = 1'b0;
        data_oe_d = 1'b0;
        if (!rd && !wr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Store is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responder builds (default, DEPTH=16, WR_WAIT=3/RD_WAIT=0)
// share one stimulus stream; each scenario checks the build it targets.
module tb_mem_bus_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] addr = '0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] data_in = '0;
  logic       init_we = 1'b0;
  logic [4:0] init_addr = '0;
  logic [7:0] init_data = '0;

  logic [7:0] dout  [3];
  logic       oe    [3];
  logic       rdy   [3];
  logic       er    [3];
  logic       bsy   [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_responder u_dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout[0]), .data_oe(oe[0]), .ready(rdy[0]), .err(er[0]), .busy(bsy[0]),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  mem_bus_responder #(.DEPTH(16)) u_d16 (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout[1]), .data_oe(oe[1]), .ready(rdy[1]), .err(er[1]), .busy(bsy[1]),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  mem_bus_responder #(.RD_WAIT(0), .WR_WAIT(3)) u_w3r0 (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data_in(data_in),
    .data_out(dout[2]), .data_oe(oe[2]), .ready(rdy[2]), .err(er[2]), .busy(bsy[2]),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    tick();
    init_we   = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_dout", dout[0], 8'h00);
    check("rst_oe",   oe[0],   1'b0);
    check("rst_rdy",  rdy[0],  1'b0);
    check("rst_err",  er[0],   1'b0);
    check("rst_busy", bsy[0],  1'b0);
    rst = 1'b0;
    tick();

    preload(5'd3, 8'hA5);
    preload(5'd2, 8'h5A);
    preload(5'd5, 8'hC3);
    preload(5'd9, 8'h11);

    // 1: read with one wait state, held four cycles
    rd = 1'b1; addr = 5'd3;
    tick();
    check("t1_k_rdy",   rdy[0], 1'b0);
    check("t1_k_busy",  bsy[0], 1'b1);
    check("t5_r0_rdy",  rdy[2], 1'b1);
    check("t5_r0_dout", dout[2], 8'hA5);
    tick();
    check("t1_k1_rdy",  rdy[0], 1'b1);
    check("t1_k1_oe",   oe[0],  1'b1);
    check("t1_k1_dout", dout[0], 8'hA5);
    tick(); tick();
    check("t1_hold_rdy", rdy[0], 1'b1);
    check("t1_hold_oe",  oe[0],  1'b1);
    rd = 1'b0;
    tick();
    check("t1_drop_rdy",  rdy[0], 1'b0);
    check("t1_drop_oe",   oe[0],  1'b0);
    check("t1_drop_dout", dout[0], 8'hA5);
    check("t1_drop_busy", bsy[0], 1'b0);

    // 2: write, data_in changes after edge k
    wr = 1'b1; addr = 5'd7; data_in = 8'h3C;
    tick();
    check("t2_k_rdy", rdy[0], 1'b0);
    data_in = 8'hFF;
    tick();
    check("t2_k1_rdy", rdy[0], 1'b1);
    check("t2_k1_oe",  oe[0],  1'b0);
    wr = 1'b0;
    tick();
    check("t2_drop_rdy", rdy[0], 1'b0);
    rd = 1'b1;
    tick(); tick();
    check("t2_rd_rdy",  rdy[0], 1'b1);
    check("t2_rd_dout", dout[0], 8'h3C);
    rd = 1'b0;
    tick();

    // 3: rd and wr together
    rd = 1'b1; wr = 1'b1; addr = 5'd2; data_in = 8'h77;
    tick();
    check("t3_err",  er[0],  1'b1);
    check("t3_rdy",  rdy[0], 1'b0);
    check("t3_oe",   oe[0],  1'b0);
    tick();
    check("t3_err_hold", er[0], 1'b1);
    rd = 1'b0; wr = 1'b0;
    tick();
    check("t3_err_clr", er[0], 1'b0);
    rd = 1'b1;
    tick(); tick();
    check("t3_mem2", dout[0], 8'h5A);
    rd = 1'b0;
    tick();

    // 4: out-of-range read on the DEPTH=16 build
    rd = 1'b1; addr = 5'd20;
    tick();
    check("t4_err", er[1], 1'b1);
    check("t4_oe",  oe[1], 1'b0);
    check("t4_rdy", rdy[1], 1'b0);
    rd = 1'b0;
    tick();
    check("t4_err_clr", er[1], 1'b0);
    rd = 1'b1; addr = 5'd5;
    tick(); tick();
    check("t4_rdy5",  rdy[1], 1'b1);
    check("t4_dout5", dout[1], 8'hC3);
    rd = 1'b0;
    tick();

    // 5: aborted write on the WR_WAIT=3 build
    wr = 1'b1; addr = 5'd9; data_in = 8'hEE;
    tick();
    check("t5_wr_busy", bsy[2], 1'b1);
    wr = 1'b0;
    tick();
    check("t5_abort_busy", bsy[2], 1'b0);
    check("t5_abort_rdy",  rdy[2], 1'b0);
    rd = 1'b1;
    tick();
    check("t5_mem9_r0", dout[2], 8'h11);
    tick();
    check("t5_mem9_def", dout[0], 8'h11);
    rd = 1'b0;
    tick();

    // 6: reset mid-wait, with a preload attempt while busy
    rd = 1'b1; addr = 5'd3;
    init_we = 1'b1; init_addr = 5'd3; init_data = 8'h00;
    tick();
    check("t6_busy", bsy[0], 1'b1);
    rst = 1'b1;
    #2;
    check("t6_rst_busy", bsy[0],  1'b0);
    check("t6_rst_rdy",  rdy[0],  1'b0);
    check("t6_rst_oe",   oe[0],   1'b0);
    check("t6_rst_err",  er[0],   1'b0);
    check("t6_rst_dout", dout[0], 8'h00);
    rst = 1'b0;
    init_we = 1'b0;
    tick();
    check("t6_re_rdy0", rdy[0], 1'b0);
    tick();
    check("t6_re_rdy",  rdy[0], 1'b1);
    check("t6_re_dout", dout[0], 8'hA5);
    rd = 1'b0;
    tick();
    check("t6_end_busy", bsy[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the CPU controller's memory bus.
- Services level-held rd/wr requests from the controller with a configurable number of wait states, and drives read data with an output-enable.
- Accepts write data while the controller drives data_e.
- Owns the program/data store and has a side port for preloading it, used by the bench and the boot loader.

Parameters:
ADDR_WIDTH, 5, width of addr and init_addr
DATA_WIDTH, 8, word width
DEPTH, 32, implemented words; addresses >= DEPTH are out of range
RD_WAIT, 1, wait cycles before read data is valid (0..15)
WR_WAIT, 1, wait cycles before a write commits (0..15)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
addr  input  ADDR_WIDTH  request address from the CPU address mux
rd  input  1  read request, level, held by the initiator
wr  input  1  write request, level, held by the initiator
data_in  input  DATA_WIDTH  write data, valid while wr=1
data_out  output  DATA_WIDTH  read data, registered
data_oe  output  1  responder is driving data_out onto the shared bus
ready  output  1  access complete; held until the request drops
err  output  1  request rejected; held until the request drops
busy  output  1  state != IDLE
init_we  input  1  preload write strobe
init_addr  input  ADDR_WIDTH  preload address
init_data  input  DATA_WIDTH  preload data

Behaviour:
- Reset: state=IDLE; data_out=0, data_oe=0, ready=0, err=0, busy=0; wait counter=0.
- Memory array is NOT cleared by reset. Contents survive reset mid-operation.
- All outputs are registered. Edge k is the first rising edge at which IDLE samples a request.
- States: IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD, ERR.
- IDLE handling at each edge:
  - rd=1 and wr=1: go to ERR (protocol error).
  - rd or wr with addr >= DEPTH: go to ERR.
  - rd=1: latch addr into addr_q, counter=RD_WAIT.
    - RD_WAIT=0: data_out<=mem[addr], data_oe<=1, ready<=1, go to RD_HOLD at edge k.
    - Otherwise: go to RD_WAIT.
  - wr=1: latch addr_q and data_q (from data_in), counter=WR_WAIT.
    - WR_WAIT=0: commit mem[addr]<=data_in, ready<=1, go to WR_HOLD at edge k.
    - Otherwise: go to WR_WAIT.
- RD_WAIT: counter decrements each edge.
  - At the edge where it reaches 0: data_out<=mem[addr_q], data_oe<=1, ready<=1, go to RD_HOLD.
  - Net effect: ready rises at edge k+RD_WAIT.
- WR_WAIT: same counting. At the final edge: mem[addr_q]<=data_q, ready<=1, go to WR_HOLD.
- RD_HOLD / WR_HOLD: hold ready, and in RD_HOLD also data_oe and data_out. Leave only when the request drops.
  - When the originating request (rd or wr) is sampled 0: ready=0, data_oe=0, go to IDLE. data_out keeps its last value.
  - addr changes while holding are ignored, since the address is latched.
  - A new request requires a return through IDLE, i.e. at least one edge with rd=wr=0.
- ERR: err=1, ready=0, data_oe=0, no memory access. When rd=wr=0 is sampled, err=0 and go to IDLE.
- Abort: if the request drops during RD_WAIT/WR_WAIT, go to IDLE with no ready pulse and no memory update.
  - A write is committed only on the final wait edge.
- Request switch during a wait (e.g. rd drops and wr rises on the same edge): treated as an abort; the new request is taken from IDLE on a later edge.
- data_in is sampled only at edge k. A later data_in change does not alter the committed value.
- Preload: init_we is honoured only when state=IDLE and rd=wr=0, writing mem[init_addr]<=init_data at that edge.
  - Otherwise it is ignored.
  - init_addr >= DEPTH is ignored.
- Read-after-write to the same address returns the new value. The write commits before WR_HOLD, so there is no bypass hazard.
- Counter width is 4 bits. WAIT parameters outside 0..15 are illegal (elaboration check).

Test Plan:
1. Reset, then preload mem[3]=8'hA5 and hold rd=1, addr=3 for 4 cycles (RD_WAIT=1) -> ready and data_oe rise at edge k+1, data_out=8'hA5, both held until rd drops. Then ready=0 and data_oe=0 one edge later.
2. wr=1, addr=7, data_in=8'h3C; change data_in to 8'hFF after edge k (WR_WAIT=1). Drop wr, then read addr 7 -> data_out=8'h3C.
3. rd=1 and wr=1 together at addr 2 -> err=1 from edge k, ready=0, mem[2] unchanged. err clears the edge after both drop.
4. Build with DEPTH=16 and issue rd at addr 20 -> err=1, data_oe=0. A subsequent rd at addr 5 completes normally.
5. Abort and zero-wait:
   - WR_WAIT=3: drop wr after 1 cycle at addr 9 (old value 8'h11) -> no ready, mem[9] stays 8'h11.
   - RD_WAIT=0: ready rises at edge k.
6. Assert rst during RD_WAIT -> all outputs 0, state IDLE, preloaded contents intact (re-read returns the prior value). init_we while busy is ignored.
